// File: rtl/retire_trace_buffer_pkg.sv
// Shared record kinds, classifier and default-width record layout for the retire trace buffer.
package trace_pkg;

    localparam int unsigned KIND_W        = 3;
    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_REG_SEL_W = 3;
    localparam int unsigned DEF_CNT_W     = 32;

    typedef enum logic [KIND_W-1:0] {
        KIND_NOP   = 3'd0,
        KIND_ALU   = 3'd1,
        KIND_LOAD  = 3'd2,
        KIND_STU   = 3'd3,
        KIND_STORE = 3'd4,
        KIND_HALT  = 3'd5
    } kind_e;

    // Field order is shared with the parameter-width record built in the top level.
    typedef struct packed {
        kind_e                    kind;
        logic [DEF_CNT_W-1:0]     inum;
        logic [DEF_DATA_W-1:0]    pc;
        logic [DEF_REG_SEL_W-1:0] reg_sel;
        logic [DEF_DATA_W-1:0]    reg_data;
        logic [DEF_DATA_W-1:0]    mem_addr;
        logic [DEF_DATA_W-1:0]    mem_data;
    } trace_rec_t;

    function automatic kind_e classify(input logic halt, input logic reg_write,
                                       input logic mem_read, input logic mem_write);
        if (halt)                        return KIND_HALT;
        else if (reg_write && mem_write) return KIND_STU;
        else if (reg_write && mem_read)  return KIND_LOAD;
        else if (reg_write)              return KIND_ALU;
        else if (mem_write)              return KIND_STORE;
        else                             return KIND_NOP;
    endfunction

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Commit-event input and trace-record output bundle of the retire trace buffer.
interface retire_trace_buffer_if
    import trace_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned REG_SEL_W = 3,
    parameter int unsigned CNT_W     = 32
);
    logic                 ev_valid;
    logic [DATA_W-1:0]    ev_pc;
    logic                 ev_reg_write;
    logic [REG_SEL_W-1:0] ev_reg_sel;
    logic [DATA_W-1:0]    ev_reg_data;
    logic                 ev_mem_read;
    logic                 ev_mem_write;
    logic [DATA_W-1:0]    ev_mem_addr;
    logic [DATA_W-1:0]    ev_mem_data;
    logic                 ev_halt;

    logic                 out_valid;
    logic                 out_ready;
    logic [KIND_W-1:0]    out_kind;
    logic [CNT_W-1:0]     out_inum;
    logic [DATA_W-1:0]    out_pc;
    logic [REG_SEL_W-1:0] out_reg_sel;
    logic [DATA_W-1:0]    out_reg_data;
    logic [DATA_W-1:0]    out_mem_addr;
    logic [DATA_W-1:0]    out_mem_data;

    // Producer of commit events and consumer of trace records.
    modport master (
        output ev_valid, ev_pc, ev_reg_write, ev_reg_sel, ev_reg_data,
        output ev_mem_read, ev_mem_write, ev_mem_addr, ev_mem_data, ev_halt,
        output out_ready,
        input  out_valid, out_kind, out_inum, out_pc, out_reg_sel, out_reg_data,
        input  out_mem_addr, out_mem_data
    );

    modport slave (
        input  ev_valid, ev_pc, ev_reg_write, ev_reg_sel, ev_reg_data,
        input  ev_mem_read, ev_mem_write, ev_mem_addr, ev_mem_data, ev_halt,
        input  out_ready,
        output out_valid, out_kind, out_inum, out_pc, out_reg_sel, out_reg_data,
        output out_mem_addr, out_mem_data
    );

endinterface

// File: rtl/retire_trace_buffer_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers; a push into a full FIFO is taken only
// when a pop frees a slot on the same edge.
module trace_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement-event recorder: classifies commit events, numbers them and queues trace records,
// with drop accounting and a halt/drain handshake.
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned REG_SEL_W = 3,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    retire_trace_buffer_if.slave bus,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow,
    output logic              halted,
    output logic              done
);
    typedef struct packed {
        kind_e                kind;
        logic [CNT_W-1:0]     inum;
        logic [DATA_W-1:0]    pc;
        logic [REG_SEL_W-1:0] reg_sel;
        logic [DATA_W-1:0]    reg_data;
        logic [DATA_W-1:0]    mem_addr;
        logic [DATA_W-1:0]    mem_data;
    } rec_t;

    logic [CNT_W-1:0] r_inum;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_drop_count;
    logic             r_overflow;
    logic             r_halted;
    logic             r_done;

    logic  w_capture;
    logic  w_pop;
    logic  w_drop;
    logic  w_full;
    logic  w_empty;
    kind_e w_kind;
    rec_t  w_rec;
    rec_t  w_head;
    rec_t  w_out;

    assign w_capture = bus.ev_valid && !r_halted;
    assign w_pop     = !w_empty && bus.out_ready;
    assign w_drop    = w_capture && w_full && !w_pop;

    // Only the fields meaningful for the record kind are kept; the rest read as zero.
    always_comb begin
        w_kind       = classify(bus.ev_halt, bus.ev_reg_write, bus.ev_mem_read, bus.ev_mem_write);
        w_rec        = '0;
        w_rec.kind   = w_kind;
        w_rec.inum   = r_inum;
        w_rec.pc     = bus.ev_pc;
        case (w_kind)
            KIND_ALU: begin
                w_rec.reg_sel  = bus.ev_reg_sel;
                w_rec.reg_data = bus.ev_reg_data;
            end
            KIND_LOAD: begin
                w_rec.reg_sel  = bus.ev_reg_sel;
                w_rec.reg_data = bus.ev_reg_data;
                w_rec.mem_addr = bus.ev_mem_addr;
            end
            KIND_STU: begin
                w_rec.reg_sel  = bus.ev_reg_sel;
                w_rec.reg_data = bus.ev_reg_data;
                w_rec.mem_addr = bus.ev_mem_addr;
                w_rec.mem_data = bus.ev_mem_data;
            end
            KIND_STORE: begin
                w_rec.mem_addr = bus.ev_mem_addr;
                w_rec.mem_data = bus.ev_mem_data;
            end
            default: ;
        endcase
    end

    trace_sync_fifo #(
        .WIDTH ($bits(rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_capture),
        .i_pop   (w_pop),
        .i_data  (w_rec),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_inum        <= '0;
            r_cycle_count <= '0;
            r_drop_count  <= '0;
            r_overflow    <= 1'b0;
            r_halted      <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
            if (w_capture) r_inum <= r_inum + CNT_W'(1);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) r_drop_count <= r_drop_count + CNT_W'(1);
            end
            // Halt sticks even if the HALT record itself was dropped.
            if (w_capture && bus.ev_halt) r_halted <= 1'b1;
            r_done <= r_halted && w_empty;
        end
    end

    assign w_out            = w_empty ? '0 : w_head;
    assign bus.out_valid    = !w_empty;
    assign bus.out_kind     = w_out.kind;
    assign bus.out_inum     = w_out.inum;
    assign bus.out_pc       = w_out.pc;
    assign bus.out_reg_sel  = w_out.reg_sel;
    assign bus.out_reg_data = w_out.reg_data;
    assign bus.out_mem_addr = w_out.mem_addr;
    assign bus.out_mem_data = w_out.mem_data;

    assign cycle_count = r_cycle_count;
    assign drop_count  = r_drop_count;
    assign overflow    = r_overflow;
    assign halted      = r_halted;
    assign done        = r_done;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed self-checking bench for retire_trace_buffer (DATA_W=16, DEPTH=16, CNT_W=32).
module tb_retire_trace_buffer;

    logic        clk;
    logic        rst;
    logic [31:0] cycle_count;
    logic [31:0] drop_count;
    logic        overflow;
    logic        halted;
    logic        done;

    int n_tests;
    int n_fail;
    int exp_cyc;

    retire_trace_buffer_if #(.DATA_W(16), .REG_SEL_W(3), .CNT_W(32)) bus ();

    retire_trace_buffer #(
        .DATA_W    (16),
        .REG_SEL_W (3),
        .DEPTH     (16),
        .CNT_W     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .cycle_count (cycle_count),
        .drop_count  (drop_count),
        .overflow    (overflow),
        .halted      (halted),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; the expected cycle counter is modelled from the sampled reset.
    task automatic step();
        @(posedge clk);
        if (rst) exp_cyc++;
        else     exp_cyc = 0;
        #1;
    endtask

    task automatic clear_ev();
        bus.ev_valid     = 1'b0;
        bus.ev_pc        = '0;
        bus.ev_reg_write = 1'b0;
        bus.ev_reg_sel   = '0;
        bus.ev_reg_data  = '0;
        bus.ev_mem_read  = 1'b0;
        bus.ev_mem_write = 1'b0;
        bus.ev_mem_addr  = '0;
        bus.ev_mem_data  = '0;
        bus.ev_halt      = 1'b0;
    endtask

    task automatic set_alu(input logic [15:0] pc, input logic [2:0] sel, input logic [15:0] d);
        clear_ev();
        bus.ev_valid     = 1'b1;
        bus.ev_pc        = pc;
        bus.ev_reg_write = 1'b1;
        bus.ev_reg_sel   = sel;
        bus.ev_reg_data  = d;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        exp_cyc       = 0;
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        clear_ev();
        step();
        step();
        check("rst_valid", bus.out_valid, 0);
        check("rst_cycle", cycle_count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_halted", halted, 0);
        check("rst_done", done, 0);
        rst = 1'b1;

        // ALU, LOAD, STORE with the consumer always ready.
        bus.out_ready = 1'b1;
        set_alu(16'h0002, 3'd3, 16'h00AB);
        check("alu_no_bypass", bus.out_valid, 0);
        step();
        check("alu_valid", bus.out_valid, 1);
        check("cycle_1", cycle_count, 1);
        set_alu(16'h0004, 3'd2, 16'h0077);
        bus.ev_mem_read = 1'b1;
        bus.ev_mem_addr = 16'h0010;
        check("alu_kind", bus.out_kind, 1);
        check("alu_inum", bus.out_inum, 0);
        check("alu_pc", bus.out_pc, 16'h0002);
        check("alu_sel", bus.out_reg_sel, 3);
        check("alu_data", bus.out_reg_data, 16'h00AB);
        check("alu_maddr", bus.out_mem_addr, 0);
        step();
        clear_ev();
        bus.ev_valid     = 1'b1;
        bus.ev_pc        = 16'h0006;
        bus.ev_mem_write = 1'b1;
        bus.ev_mem_addr  = 16'h0030;
        bus.ev_mem_data  = 16'h1234;
        bus.ev_reg_sel   = 3'd5;
        bus.ev_reg_data  = 16'hFFFF;
        check("load_kind", bus.out_kind, 2);
        check("load_inum", bus.out_inum, 1);
        check("load_addr", bus.out_mem_addr, 16'h0010);
        check("load_rdata", bus.out_reg_data, 16'h0077);
        check("load_mdata", bus.out_mem_data, 0);
        step();
        clear_ev();
        check("store_kind", bus.out_kind, 4);
        check("store_inum", bus.out_inum, 2);
        check("store_mdata", bus.out_mem_data, 16'h1234);
        check("store_rdata", bus.out_reg_data, 0);
        check("store_rsel", bus.out_reg_sel, 0);
        step();
        check("drained_valid", bus.out_valid, 0);

        // Reset with five records queued discards them.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_alu(16'h0200 + 16'(i), 3'(i), 16'(i));
            step();
        end
        clear_ev();
        check("pre_rst_valid", bus.out_valid, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_pc", bus.out_pc, 0);
        check("mid_rst_cycle", cycle_count, 0);
        check("mid_rst_drop", drop_count, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_halted", halted, 0);

        // 20 ALU events into a 16-deep FIFO with no consumer.
        for (int i = 0; i < 20; i++) begin
            set_alu(16'h0100 + 16'(i), 3'(i), 16'(i));
            step();
        end
        clear_ev();
        check("ovf_drop", drop_count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head_inum", bus.out_inum, 0);
        check("ovf_head_pc", bus.out_pc, 16'h0100);

        // Full FIFO: simultaneous push and pop must not drop.
        bus.out_ready = 1'b1;
        set_alu(16'h0BEE, 3'd7, 16'hBEEF);
        step();
        clear_ev();
        check("full_pp_drop", drop_count, 4);
        for (int k = 1; k < 16; k++) begin
            check($sformatf("drain_inum_%0d", k), bus.out_inum, k);
            step();
        end
        check("last_inum", bus.out_inum, 20);
        check("last_pc", bus.out_pc, 16'h0BEE);
        step();
        check("pp_empty", bus.out_valid, 0);

        // STU record carries all four data fields.
        set_alu(16'h0050, 3'd1, 16'h5555);
        bus.ev_mem_write = 1'b1;
        bus.ev_mem_addr  = 16'h0020;
        bus.ev_mem_data  = 16'h5555;
        step();
        clear_ev();
        check("stu_kind", bus.out_kind, 3);
        check("stu_inum", bus.out_inum, 21);
        check("stu_sel", bus.out_reg_sel, 1);
        check("stu_rdata", bus.out_reg_data, 16'h5555);
        check("stu_addr", bus.out_mem_addr, 16'h0020);
        check("stu_mdata", bus.out_mem_data, 16'h5555);
        step();

        // HALT behind two queued records, then events that must be ignored.
        bus.out_ready = 1'b0;
        set_alu(16'h0060, 3'd2, 16'h0001);
        step();
        set_alu(16'h0062, 3'd2, 16'h0002);
        step();
        clear_ev();
        bus.ev_valid = 1'b1;
        bus.ev_pc    = 16'h0040;
        bus.ev_halt  = 1'b1;
        check("pre_halt", halted, 0);
        step();
        check("halted", halted, 1);
        for (int i = 0; i < 3; i++) begin
            set_alu(16'h0070 + 16'(i), 3'd4, 16'h0AAA);
            step();
        end
        clear_ev();
        check("halt_hold_kind", bus.out_kind, 1);
        check("halt_hold_inum", bus.out_inum, 22);
        check("halt_done_early", done, 0);
        bus.out_ready = 1'b1;
        step();
        check("halt_q2_inum", bus.out_inum, 23);
        step();
        check("halt_kind", bus.out_kind, 5);
        check("halt_inum", bus.out_inum, 24);
        check("halt_pc", bus.out_pc, 16'h0040);
        check("halt_rdata", bus.out_reg_data, 0);
        step();
        check("halt_empty", bus.out_valid, 0);
        check("done_not_yet", done, 0);
        step();
        check("done", done, 1);
        check("post_halt_drop", drop_count, 4);
        step();
        check("cycle_runs", cycle_count, 32'(exp_cyc));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
